// File: rtl/mpi_send_packetizer.sv
// -----------------------------------------------------------------------------
// mpi_send_packetizer
//
// Purpose:
//   Send side of the MPI matching path. Send requests {dest, tag, payload} are
//   queued in a small FIFO. A three-state FSM (IDLE -> LOAD -> HOLD) takes the
//   head request and formats it as a 128-bit network message. The FSM then
//   holds that message on a valid/ready handshake until the network accepts it.
//   Bits [103:88] = {src rank, tag} match the pattern that the receive-side
//   unexpected-message CAM looks up.
//
// Message layout (unlisted bits are zero):
//   [127:120] 8'hA5 start marker   [112]    parity (PKT_PARITY_EN only)
//   [111:104] dest rank            [103:96] MY_RANK (source)
//   [95:88]   tag                  [87:56]  payload
//   [55:40]   sequence number
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   send_valid    send request present
//   send_ready    FIFO can accept (= !fifo_full)
//   send_dest     destination rank
//   send_tag      message tag
//   send_data     32-bit payload
//   net_valid     message valid toward network
//   net_ready     network accepts message
//   message       formatted network message
//   fifo_empty    request FIFO empty
//   fifo_full     request FIFO full
//   busy          FSM not in IDLE
//   sent_count    messages accepted by the network (wraps at 16 bits)
//
// Configuration macro:
//   PKT_PARITY_EN  when defined, message[112] = ^message[103:56] (even parity
//                  over {src, tag, payload}). When undefined, bit 112 is 0.
// -----------------------------------------------------------------------------
module mpi_send_packetizer #(
    parameter int packetizer_width = 128,
    parameter int RANK_BIT         = 8,
    parameter int TAG_BIT          = 8,
    parameter int FIFO_AW          = 2,
    parameter int MY_RANK          = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        send_valid,
    output logic                        send_ready,
    input  logic [RANK_BIT-1:0]         send_dest,
    input  logic [TAG_BIT-1:0]          send_tag,
    input  logic [31:0]                 send_data,
    output logic                        net_valid,
    input  logic                        net_ready,
    output logic [packetizer_width-1:0] message,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic                        busy,
    output logic [15:0]                 sent_count
);

    localparam int                LP_REQ_W   = RANK_BIT + TAG_BIT + 32;
    localparam int                LP_DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  LP_PTR_ONE = 1;
    localparam logic [RANK_BIT-1:0] LP_MY_RANK = RANK_BIT'(MY_RANK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LP_REQ_W-1:0]         r_mem [LP_DEPTH];
    logic [FIFO_AW:0]            r_wr_ptr;
    logic [FIFO_AW:0]            r_rd_ptr;
    logic [LP_REQ_W-1:0]         r_hold;
    logic [packetizer_width-1:0] r_message;
    logic                        r_net_valid;
    logic [15:0]                 r_seq;
    logic [15:0]                 r_sent_count;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_load;
    logic                        w_accept;
    logic [RANK_BIT-1:0]         w_hold_dest;
    logic [TAG_BIT-1:0]          w_hold_tag;
    logic [31:0]                 w_hold_data;
    logic [packetizer_width-1:0] w_msg_build;

    // -------------------------------------------------------------------------
    // FIFO status. The extra pointer MSB tells full apart from empty when
    // the index bits are equal.
    // -------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_push  = send_valid && !w_full;

    // The FIFO storage and the holding register carry no reset. Reset empties
    // the FIFO through the pointers, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {send_dest, send_tag, send_data};
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_hold <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
        end
    end

    assign w_hold_dest = r_hold[LP_REQ_W-1 -: RANK_BIT];
    assign w_hold_tag  = r_hold[32 +: TAG_BIT];
    assign w_hold_data = r_hold[31:0];

    // -------------------------------------------------------------------------
    // Message formatter, used in LOAD. The sequence number is sampled here;
    // it changes only on acceptance, so it matches the message being built.
    // -------------------------------------------------------------------------
    always_comb begin
        w_msg_build               = '0;
        w_msg_build[127:120]      = 8'hA5;
        w_msg_build[104 +: RANK_BIT] = w_hold_dest;
        w_msg_build[96 +: RANK_BIT]  = LP_MY_RANK;
        w_msg_build[88 +: TAG_BIT]   = w_hold_tag;
        w_msg_build[87:56]        = w_hold_data;
        w_msg_build[55:40]        = r_seq;
`ifdef PKT_PARITY_EN
        w_msg_build[112]          = ^{LP_MY_RANK, w_hold_tag, w_hold_data};
`else
        w_msg_build[112]          = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // FSM: next state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                // net_valid is high in HOLD, so net_ready counts only here.
                if (net_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_net_valid  <= 1'b0;
            r_message    <= '0;
            r_seq        <= '0;
            r_sent_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_load) begin
                r_message   <= w_msg_build;
                r_net_valid <= 1'b1;
            end
            // The message register stays unchanged after acceptance until
            // the next LOAD. It is never written while net_valid is high.
            if (w_accept) begin
                r_net_valid  <= 1'b0;
                r_seq        <= r_seq + 16'd1;
                r_sent_count <= r_sent_count + 16'd1;
            end
        end
    end

    assign send_ready = !w_full;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign net_valid  = r_net_valid;
    assign message    = r_message;
    assign busy       = (r_state != S_IDLE);
    assign sent_count = r_sent_count;

endmodule
